// File: rtl/serial_logic_unit.sv
// Bit-serial NOT/AND/OR/XOR unit: LSB-first through a 1-bit gate, result done WIDTH+1 cycles after accept.
// Start is accepted in IDLE or DONE only and ignored while busy; SERIAL_LOGIC_PARITY_EN adds a parity output.
module serial_logic_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             bit_o
`ifdef SERIAL_LOGIC_PARITY_EN
  ,
  output logic             parity
`endif
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [1:0]       op_reg;
  logic             gate_bit;

  always_comb begin
    gate_bit = 1'b0;
    case (op_reg)
      2'b00:   gate_bit = ~a_reg[0];
      2'b01:   gate_bit = a_reg[0] & b_reg[0];
      2'b10:   gate_bit = a_reg[0] | b_reg[0];
      default: gate_bit = a_reg[0] ^ b_reg[0];
    endcase
  end

  // Qualified by busy so the debug bit reads 0 when idle (NOT of cleared operands would be 1).
  assign bit_o = busy & gate_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      cnt    <= '0;
      a_reg  <= '0;
      b_reg  <= '0;
      op_reg <= 2'b00;
`ifdef SERIAL_LOGIC_PARITY_EN
      parity <= 1'b0;
`endif
    end else begin
      case (state)
        SHIFT: begin
          result <= {bit_o, result[WIDTH-1:1]};
          a_reg  <= a_reg >> 1;
          b_reg  <= b_reg >> 1;
          cnt    <= cnt + 1'b1;
`ifdef SERIAL_LOGIC_PARITY_EN
          parity <= parity ^ bit_o;
`endif
          if (cnt == LAST) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          // IDLE and DONE both accept a new request.
          done <= 1'b0;
          if (start) begin
            state  <= SHIFT;
            busy   <= 1'b1;
            a_reg  <= a;
            b_reg  <= b;
            op_reg <= op;
            cnt    <= '0;
            result <= '0;
`ifdef SERIAL_LOGIC_PARITY_EN
            parity <= 1'b0;
`endif
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_logic_unit.sv
// Directed plus random bench for serial_logic_unit against a word-level reference model.
module tb_serial_logic_unit;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         bit_o;
`ifdef SERIAL_LOGIC_PARITY_EN
  logic         parity;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  serial_logic_unit #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .bit_o  (bit_o)
`ifdef SERIAL_LOGIC_PARITY_EN
    ,
    .parity (parity)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    case (o)
      2'b00:   return ~x;
      2'b01:   return x & y;
      2'b10:   return x | y;
      default: return x ^ y;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a request and clock it in; outputs sampled 1ns after the edge.
  task automatic accept(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input bit hold, output logic [W-1:0] exp);
    start = 1'b1; op = o; a = x; b = y;
    exp = model(o, x, y);
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
  endtask

  // Checks the WIDTH shift cycles and the done cycle; pulse_at>=1 injects a stray start before that edge.
  task automatic run(input logic [W-1:0] exp, input int pulse_at, input logic [W-1:0] pulse_a);
    check("busy_after_accept", {31'd0, busy}, 32'd1);
    check("done_after_accept", {31'd0, done}, 32'd0);
    for (int k = 1; k <= W; k++) begin
      check("bit_o", {31'd0, bit_o}, {31'd0, exp[k-1]});
      if (k == pulse_at) begin
        start = 1'b1; a = pulse_a; op = 2'b00;
      end else if (k == pulse_at + 1) begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (k < W) begin
        check("busy_mid", {31'd0, busy}, 32'd1);
        check("done_mid", {31'd0, done}, 32'd0);
      end else begin
        check("busy_end", {31'd0, busy}, 32'd0);
        check("done_end", {31'd0, done}, 32'd1);
        check("result", {24'd0, result}, {24'd0, exp});
`ifdef SERIAL_LOGIC_PARITY_EN
        check("parity", {31'd0, parity}, {31'd0, ^exp});
`endif
      end
    end
  endtask

  task automatic idle_after(input logic [W-1:0] exp);
    @(posedge clk); #1;
    check("done_pulse_len", {31'd0, done}, 32'd0);
    check("busy_idle", {31'd0, busy}, 32'd0);
    check("result_held", {24'd0, result}, {24'd0, exp});
  endtask

  initial begin
    logic [W-1:0] e;
    logic [W-1:0] e2;
    logic [1:0]   ro;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    rst_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
    repeat (10) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", {24'd0, result}, 32'd0);
    check("rst_bit_o", {31'd0, bit_o}, 32'd0);
`ifdef SERIAL_LOGIC_PARITY_EN
    check("rst_parity", {31'd0, parity}, 32'd0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_bit_o", {31'd0, bit_o}, 32'd0);

    // NOT of A5
    accept(2'b00, 8'hA5, 8'h00, 1'b0, e);
    check("model_not", {24'd0, e}, 32'h5A);
    run(e, -1, '0);
    idle_after(e);

    // AND / OR / XOR with fixed operands
    accept(2'b01, 8'hF0, 8'hCC, 1'b0, e);
    check("model_and", {24'd0, e}, 32'hC0);
    run(e, -1, '0); idle_after(e);
    accept(2'b10, 8'hF0, 8'hCC, 1'b0, e);
    check("model_or", {24'd0, e}, 32'hFC);
    run(e, -1, '0); idle_after(e);
    accept(2'b11, 8'hF0, 8'hCC, 1'b0, e);
    check("model_xor", {24'd0, e}, 32'h3C);
    run(e, -1, '0); idle_after(e);

    // Stray start while busy must be ignored
    accept(2'b00, 8'h0F, 8'h00, 1'b0, e);
    run(e, 3, 8'hFF);
    idle_after(e);

    // Back-to-back: start held through DONE
    accept(2'b00, 8'h01, 8'h00, 1'b1, e);
    run(e, -1, '0);
    check("b2b_first", {24'd0, result}, 32'hFE);
    accept(2'b00, 8'h80, 8'h00, 1'b0, e2);
    run(e2, -1, '0);
    check("b2b_second", {24'd0, result}, 32'h7F);
    idle_after(e2);

    // Asynchronous reset in the middle of an operation
    accept(2'b00, 8'h33, 8'h00, 1'b0, e);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_result", {24'd0, result}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int k = 0; k < W + 3; k++) begin
      @(posedge clk); #1;
      check("abort_no_done", {30'd0, done, busy}, 32'd0);
    end

`ifdef SERIAL_LOGIC_PARITY_EN
    accept(2'b00, 8'h00, 8'h00, 1'b0, e);
    run(e, -1, '0);
    check("par_ff", {23'd0, parity, result}, {23'd0, 1'b0, 8'hFF});
    accept(2'b00, 8'h01, 8'h00, 1'b0, e);
    run(e, -1, '0);
    check("par_fe", {23'd0, parity, result}, {23'd0, 1'b1, 8'hFE});
    idle_after(e);
`endif

    // Random operations, some back-to-back, inputs scrambled while shifting
    for (int i = 0; i < 30; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = 8'($urandom);
      rb = 8'($urandom);
      accept(ro, ra, rb, 1'b0, e);
      a = 8'($urandom); b = 8'($urandom); op = 2'($urandom);
      run(e, -1, '0);
      if ($urandom_range(0, 1) == 0) idle_after(e);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
